// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default baud setup and FSM states.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int CLK_HZ    = 50_000_000;
    localparam int BAUD      = 115_200;

    // Divider convention shared with the transmitter: whole clk cycles per bit.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    localparam int CLKS_PER_BIT_DEF = clks_per_bit(CLK_HZ, BAUD);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte and strobes out.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx_serial;
    logic [DATA_BITS-1:0] dout;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    // Line driver / byte consumer side.
    modport master (
        output rx_serial,
        input  dout,
        input  valid,
        input  frame_err,
        input  busy
    );

    // The receiver itself.
    modport slave (
        input  rx_serial,
        output dout,
        output valid,
        output frame_err,
        output busy
    );

endinterface

// File: rtl/uart_rx_sync_ff.sv
// Flop chain for bringing an asynchronous single-bit input into the clk domain.
// Resets to RST_VAL so an idle-high line does not look like an edge out of reset.
module sync_ff
    import uart_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the chain; the last stage is the safe copy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling via clock-count divider, LSB first.
// Emits a one-cycle valid with each good byte and a one-cycle frame_err when
// the stop bit is low; a line held low afterwards parks in BREAK until it rises.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    // Reject configurations the divider cannot honour.
    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be at least 4");
    end
    if (HALF_BIT < 0 || HALF_BIT >= CLKS_PER_BIT) begin : g_bad_half
        $error("uart_rx: HALF_BIT must lie within one bit period");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
        $error("uart_rx: SYNC_STAGES must be 2 or 3");
    end

    logic rx_s;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.rx_serial),
        .q_o (rx_s)
    );

    uart_state_e          state_q;
    logic [CNT_W-1:0]     div_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] dout_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;

    logic div_half_d;
    logic div_last_d;

    // Divider terminal counts: start-bit recheck and full bit period.
    always_comb begin
        div_half_d = (div_q == HALF_CNT);
        div_last_d = (div_q == LAST_CNT);
    end

    // Frame FSM with registered strobes; the divider clears on every state
    // change and every bit sample so each bit is timed from the previous one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        div_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (div_half_d) begin
                        div_q <= '0;
                        if (!rx_s) begin
                            state_q   <= DATA;
                            bit_idx_q <= '0;
                        end else begin
                            // Too short to be a start bit: treat as a glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                DATA: begin
                    if (div_last_d) begin
                        div_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        bit_idx_q          <= bit_idx_q + 1'b1;
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= STOP;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                STOP: begin
                    if (div_last_d) begin
                        div_q <= '0;
                        if (rx_s) begin
                            // Back to IDLE at mid-stop so a start bit that
                            // follows with no idle gap is still caught.
                            dout_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                BREAK: begin
                    // Hold off until the line releases, so a long low is not
                    // decoded as a string of zero bytes.
                    if (rx_s) begin
                        state_q <= IDLE;
                        div_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    div_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout      = dout_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver: 8N1 format, LSB first, idle-high line.
- Counterpart of the team's UART transmitter. Sits directly downstream of the line it drives, or of an external RS-232 pin.
- Converts the asynchronous serial stream into 8-bit bytes, with a one-cycle valid strobe and a framing-error strobe.
- Samples each bit at mid-bit using a clock-count divider, with the same divider convention as the transmitter.

Parameters:
- CLKS_PER_BIT, default 434 (50 MHz / 115200), clk cycles per bit period. Legal minimum is 4; elaboration fails below that.
- HALF_BIT, default (CLKS_PER_BIT-1)/2 (integer divide, 216), count at which the start bit is re-checked.
- SYNC_STAGES, default 2, number of flops in the input synchronizer. Legal range 2..3.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- rx_serial  input  1  asynchronous serial line, idle high
- dout  output  8  last correctly framed byte; holds until the next good byte
- valid  output  1  one-cycle pulse, dout newly updated
- frame_err  output  1  one-cycle pulse, stop bit sampled low
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst==0 at a clk edge) produces the following register values:
  - state=IDLE, bit counter=0, divider counter=0.
  - All synchronizer flops = 1.
  - dout=8'h00, valid=0, frame_err=0, busy=0.
- Reset mid-frame abandons the frame; no valid or frame_err is produced for it.
- Synchronizer: rx_serial passes through SYNC_STAGES flops. The FSM uses only the last stage (rx_s).
- Divider counter is $clog2(CLKS_PER_BIT) bits wide. It clears to 0 on every state change and on every bit sample.
- IDLE:
  - rx_s==0 -> START, divider=0.
  - Otherwise remain.
- START:
  - Divider increments each cycle.
  - At divider==HALF_BIT, sample rx_s:
    - 0 -> DATA, divider=0, bit index=0.
    - 1 -> IDLE. Glitch rejected, no strobes.
- DATA:
  - Divider increments.
  - At divider==CLKS_PER_BIT-1, sample rx_s into shift[bit index] (LSB first), clear divider, increment bit index.
  - After the sample with bit index==7 -> STOP.
- STOP:
  - At divider==CLKS_PER_BIT-1, sample rx_s:
    - 1 -> dout<=shift, valid=1 for the next cycle only, -> IDLE.
    - 0 -> frame_err=1 for the next cycle only, dout unchanged, -> BREAK.
- BREAK: remain until rx_s==1, then -> IDLE. This prevents a held-low line or break condition from being decoded as a stream of 0x00 bytes.
- Return to IDLE happens at mid-stop-bit, so a start bit immediately following the stop bit (zero idle time) is received.
- valid and frame_err are registered, never high together, and never high on consecutive cycles for different frames.
- Latency from the line's start-bit falling edge to valid:
  - nominal SYNC_STAGES + (HALF_BIT+1) + 9*CLKS_PER_BIT cycles, +1 for the output register;
  - bench tolerance ±2 cycles.
- Baud tolerance: must decode correctly with a transmitter-side bit period of CLKS_PER_BIT ±2%.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, STOP, BREAK);
  - DATA_BITS=8;
  - default CLK_HZ=50_000_000 and BAUD=115200 constants, used by both TX and RX for CLKS_PER_BIT.
- One natural sub-module: sync_ff (parameterised SYNC_STAGES flop chain with reset value 1), reusable for other async inputs.

Test Plan:
- Drive 0xA5 at CLKS_PER_BIT=434, 8N1 -> exactly one valid pulse, dout=8'hA5, frame_err never high, busy low afterwards.
- Low glitch of 100 clk cycles on an idle line -> return to IDLE at the HALF_BIT check, no valid, no frame_err, dout unchanged.
- 0x3C with stop bit forced 0, line held low 2000 cycles, then high, then 0x5A -> one frame_err pulse, no valid during the low hold, then valid with dout=8'h5A.
- Back-to-back 0x00, 0xFF, 0x81 with zero idle between frames -> three valid pulses, spaced 10*CLKS_PER_BIT ±2 cycles, with dout 00, FF, 81 in order.
- rst asserted low mid-byte (during bit 4) for 3 cycles, then 0x7E sent -> dout=00 and busy=0 after reset, then valid with dout=8'h7E.
- Loopback with the team's transmitter sending 0x55 and 0xC3, and separately with the bit period stretched/shrunk 2% -> received bytes match in all cases.
